// File: rtl/reg_dump_ctrl.sv
// Register-file dump/load sequencer: streams R[0..31] out as 16 paired beats,
// or writes 32 incoming words into R[0..31].
module reg_dump_ctrl #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic                cmd_op,
    output logic                cmd_ready,
    input  logic                ld_valid,
    input  logic [DWIDTH-1:0]   ld_data,
    output logic                ld_ready,
    output logic                dp_valid,
    output logic [2*DWIDTH-1:0] dp_data,
    output logic                dp_last,
    input  logic                dp_ready,
    output logic [4:0]          rf_rs1_id,
    output logic [4:0]          rf_rs2_id,
    input  logic [DWIDTH-1:0]   rf_rs1,
    input  logic [DWIDTH-1:0]   rf_rs2,
    output logic                rf_we,
    output logic [4:0]          rf_rdst_id,
    output logic [DWIDTH-1:0]   rf_rdst,
    output logic                done
);

    typedef enum logic [1:0] {StIdle, StDump, StDrain, StLoad} state_e;

    state_e              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                dp_valid_q, dp_valid_d;
    logic                dp_last_q, dp_last_d;
    logic [2*DWIDTH-1:0] dp_data_q, dp_data_d;
    logic                done_q, done_d;

    assign cmd_ready  = (state_q == StIdle);
    assign ld_ready   = (state_q == StLoad);
    assign rf_we      = ld_ready && ld_valid;
    assign rf_rdst_id = cnt_q;
    assign rf_rdst    = ld_data;
    assign rf_rs1_id  = (state_q == StDump) ? {cnt_q[3:0], 1'b0} : 5'd0;
    assign rf_rs2_id  = (state_q == StDump) ? {cnt_q[3:0], 1'b1} : 5'd0;
    assign dp_valid   = dp_valid_q;
    assign dp_last    = dp_last_q;
    assign dp_data    = dp_data_q;
    assign done       = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = dp_valid_q;
        dp_last_d  = dp_last_q;
        dp_data_d  = dp_data_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = cmd_op ? StLoad : StDump;
                    cnt_d   = 5'd0;
                end
            end
            StDump: begin
                // Output register is free when empty or being drained this cycle.
                if (!dp_valid_q || dp_ready) begin
                    dp_data_d  = {rf_rs2, rf_rs1};
                    dp_valid_d = 1'b1;
                    dp_last_d  = (cnt_q == 5'd15);
                    cnt_d      = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (dp_ready) begin
                    dp_valid_d = 1'b0;
                    dp_last_d  = 1'b0;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    if (cnt_q == 5'd31) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            dp_valid_q <= 1'b0;
            dp_last_q  <= 1'b0;
            dp_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_last_q  <= dp_last_d;
            dp_data_q  <= dp_data_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: a behavioural register file plus an expected-contents
// array; dumps and loads are checked beat by beat against that array.
module tb_reg_dump_ctrl;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_op, cmd_ready;
    logic            ld_valid, ld_ready;
    logic [DW-1:0]   ld_data;
    logic            dp_valid, dp_last, dp_ready;
    logic [2*DW-1:0] dp_data;
    logic [4:0]      rf_rs1_id, rf_rs2_id, rf_rdst_id;
    logic [DW-1:0]   rf_rs1, rf_rs2, rf_rdst;
    logic            rf_we, done;

    logic [DW-1:0]   rf [32];
    logic [DW-1:0]   exp_rf [32];
    logic            pre_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_dump_ctrl #(.DWIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .dp_valid   (dp_valid),
        .dp_data    (dp_data),
        .dp_last    (dp_last),
        .dp_ready   (dp_ready),
        .rf_rs1_id  (rf_rs1_id),
        .rf_rs2_id  (rf_rs2_id),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_we      (rf_we),
        .rf_rdst_id (rf_rdst_id),
        .rf_rdst    (rf_rdst),
        .done       (done)
    );

    // Register file seen by the DUT: combinational reads, write on posedge.
    assign rf_rs1 = rf[rf_rs1_id];
    assign rf_rs2 = rf[rf_rs2_id];

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i * 32'h11);
        end else if (rf_we) begin
            rf[rf_rdst_id] <= rf_rdst;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        @(negedge clk);
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'(i * 32'h11);
    endtask

    task automatic compare_rf();
        for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), 64'(rf[i]), 64'(exp_rf[i]));
    endtask

    // mode 0: dp_ready held 1; 1: toggling; 2: random.  hold_cmd keeps cmd_valid high.
    task automatic do_dump(input int mode, input bit hold_cmd);
        int          k = 0;
        int          cyc = 0;
        int          accepts;
        logic [63:0] held = '0;
        logic        was_stall = 1'b0;
        logic [63:0] beat;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        dp_ready  = 1'b1;
        #1;
        check("dump_accept", 64'(cmd_ready), 64'd1);
        accepts = 1;
        while (k < 16 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            cmd_valid = hold_cmd;
            cmd_op    = 1'b1;
            if (mode == 0)      dp_ready = 1'b1;
            else if (mode == 1) dp_ready = cyc[0];
            else                dp_ready = 1'($urandom_range(0, 1));
            #1;
            if (cmd_valid && cmd_ready) accepts++;
            check("dump_done_low", 64'(done), 64'd0);
            check("dump_no_we", 64'(rf_we), 64'd0);
            if (was_stall) begin
                check("dump_hold_valid", 64'(dp_valid), 64'd1);
                check("dump_hold_data", dp_data, held);
            end
            if (dp_valid && dp_ready) begin
                beat = {exp_rf[2*k+1], exp_rf[2*k]};
                check($sformatf("dump_beat%0d", k), dp_data, beat);
                check($sformatf("dump_last%0d", k), 64'(dp_last), 64'(k == 15));
                if (mode == 0) check("dump_latency", 64'(cyc), 64'(k + 2));
                k++;
            end
            was_stall = dp_valid && !dp_ready;
            held      = dp_data;
        end
        if (k < 16) check("dump_timeout", 64'(k), 64'd16);
        @(negedge clk);
        cmd_valid = 1'b0;
        dp_ready  = 1'b1;
        #1;
        check("dump_done", 64'(done), 64'd1);
        check("dump_valid_clr", 64'(dp_valid), 64'd0);
        check("dump_idle", 64'(cmd_ready), 64'd1);
        if (hold_cmd) check("dump_accepts", 64'(accepts), 64'd1);
        @(negedge clk);
        #1;
        check("dump_done_pulse", 64'(done), 64'd0);
    endtask

    // mode 0: ld_valid gapped every 3rd cycle, incrementing data; 1: random valid and data.
    task automatic do_load(input int n_words, input int mode);
        int idx = 0;
        int cyc = 0;
        int we_n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        ld_valid  = 1'b0;
        #1;
        check("load_accept", 64'(cmd_ready), 64'd1);
        while (idx < n_words && cyc < 300) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            ld_valid  = (mode == 0) ? (cyc % 3 != 0) : 1'($urandom_range(0, 1));
            ld_data   = (mode == 0) ? 32'hA000_0000 + 32'(idx) : $urandom;
            #1;
            check("load_ready", 64'(ld_ready), 64'd1);
            check("load_we", 64'(rf_we), 64'(ld_valid));
            check("load_done_low", 64'(done), 64'd0);
            if (rf_we) begin
                we_n++;
                check("load_id", 64'(rf_rdst_id), 64'(idx));
                check("load_data", 64'(rf_rdst), 64'(ld_data));
            end
            if (ld_valid) begin
                exp_rf[idx] = ld_data;
                idx++;
            end
        end
        if (idx < n_words) check("load_timeout", 64'(idx), 64'(n_words));
        check("load_we_count", 64'(we_n), 64'(n_words));
        if (n_words == 32) begin
            @(negedge clk);
            ld_valid = 1'b0;
            #1;
            check("load_done", 64'(done), 64'd1);
            check("load_ready_clr", 64'(ld_ready), 64'd0);
            @(negedge clk);
            #1;
            check("load_done_pulse", 64'(done), 64'd0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        pre_en    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        dp_ready  = 1'b0;
        #1;
        check("rst_dp_valid", 64'(dp_valid), 64'd0);
        check("rst_dp_last", 64'(dp_last), 64'd0);
        check("rst_dp_data", dp_data, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        preload();
        do_dump(0, 1'b0);
        do_dump(1, 1'b0);
        do_dump(2, 1'b1);

        do_load(32, 0);
        compare_rf();
        do_dump(0, 1'b0);

        // Abort a load after five words.
        preload();
        do_load(5, 0);
        @(negedge clk);
        ld_valid = 1'b1;
        rst      = 1'b0;
        #1;
        check("abort_we", 64'(rf_we), 64'd0);
        check("abort_ld_ready", 64'(ld_ready), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_done", 64'(done), 64'd0);
            check("abort_idle", 64'(cmd_ready), 64'd1);
        end
        compare_rf();

        do_load(32, 1);
        compare_rf();
        do_dump(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
